// File: rtl/parity_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_rx_if
// Brief    : Serial line input and parallel word/status bundle of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface parity_serial_rx_if #(
   parameter int DATA_W = 4
);
   logic              rx_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              busy;

   // master drives the line and consumes the word; slave is the receiver
   modport master (
      output rx_in,
      input  data_out, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  rx_in,
      output data_out, data_valid, parity_err, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/parity_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_rx
// Brief    : Idle-high LSB-first serial deserializer with parity/stop checking.
// Revision : 1.0 - initial release
// ============================================================================
module parity_serial_rx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   parity_serial_rx_if.slave  bus
);

   localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
   localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
   localparam logic               c_ODD      = (PARITY_ODD != 0);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_START     = 3'd1;
   localparam logic [2:0] c_DATA      = 3'd2;
   localparam logic [2:0] c_PARITY    = 3'd3;
   localparam logic [2:0] c_STOP      = 3'd4;
   localparam logic [2:0] c_WAIT_IDLE = 3'd5;

   logic               r_sync1;
   logic               r_sync2;
   logic [2:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_IDX_W-1:0] r_idx;
   logic [DATA_W-1:0]  r_shift;
   logic               r_par_bit;
   logic [DATA_W-1:0]  r_data_out;
   logic               r_data_valid;
   logic               r_parity_err;
   logic               r_frame_err;

   logic               w_rx_s;
   logic               w_cnt_last;
   logic               w_par_err;

   // Line is asynchronous; idle-high reset keeps reset release from faking a start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rx_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s     = r_sync2;
   assign w_cnt_last = (r_cnt == c_CNT_LAST);
   assign w_par_err  = ((^r_shift) ^ r_par_bit) != c_ODD;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_par_bit    <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= c_START;
                  r_cnt   <= '0;
               end
            end
            c_START: begin
               // Mid-start-bit recheck rejects short glitches
               if (r_cnt == c_CNT_HALF) begin
                  r_cnt <= '0;
                  if (!w_rx_s) begin
                     r_state <= c_DATA;
                     r_idx   <= '0;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_DATA: begin
               if (w_cnt_last) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= w_rx_s;
                  if (r_idx == c_IDX_LAST) begin
                     r_state <= c_PARITY;
                  end else begin
                     r_idx <= r_idx + c_IDX_ONE;
                  end
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_PARITY: begin
               if (w_cnt_last) begin
                  r_cnt     <= '0;
                  r_par_bit <= w_rx_s;
                  r_state   <= c_STOP;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_STOP: begin
               if (w_cnt_last) begin
                  r_cnt        <= '0;
                  r_data_out   <= r_shift;
                  r_parity_err <= w_par_err;
                  r_frame_err  <= ~w_rx_s;
                  r_data_valid <= 1'b1;
                  // A low stop may be a break; wait for idle so it reports once
                  r_state      <= w_rx_s ? c_IDLE : c_WAIT_IDLE;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            c_WAIT_IDLE: begin
               if (w_rx_s) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_data_valid;
   assign bus.parity_err = r_parity_err;
   assign bus.frame_err  = r_frame_err;
   assign bus.busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_serial_rx
// Brief    : Directed, table-driven bench for parity_serial_rx (even and odd).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_serial_rx;

   localparam int c_N = 4;

   typedef struct {
      logic [3:0] data;
      logic       par_flip;
      logic       stop;
      logic [3:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   typedef struct {
      logic [3:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } pulse_t;

   logic clk;
   logic rst_n;
   logic rx0;
   logic rx1;
   int   cyc;
   int   checks;
   int   errors;
   int   n_pulse0;
   int   n_pulse1;
   pulse_t q0[$];
   pulse_t q1[$];

   parity_serial_rx_if #(.DATA_W(4)) bus0 ();
   parity_serial_rx_if #(.DATA_W(4)) bus1 ();

   assign bus0.rx_in = rx0;
   assign bus1.rx_in = rx1;

   parity_serial_rx #(.DATA_W(4), .CLKS_PER_BIT(c_N), .PARITY_ODD(0)) u_dut_even (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   parity_serial_rx #(.DATA_W(4), .CLKS_PER_BIT(c_N), .PARITY_ODD(1)) u_dut_odd (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      n_pulse0 = 0;
      n_pulse1 = 0;
   end

   always @(posedge clk) begin
      #1;
      if (bus0.data_valid) begin
         q0.push_back('{data: bus0.data_out, perr: bus0.parity_err, ferr: bus0.frame_err, cyc: cyc});
         n_pulse0++;
      end
      if (bus1.data_valid) begin
         q1.push_back('{data: bus1.data_out, perr: bus1.parity_err, ferr: bus1.frame_err, cyc: cyc});
         n_pulse1++;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic set_line(input bit which, input logic v);
      if (which) rx1 = v;
      else       rx0 = v;
   endtask

   // Called at a negedge; each bit is held for c_N clocks, leaves the line at the stop level
   task automatic send_frame(input bit which, input logic [3:0] d, input logic p,
                             input logic s, output int c);
      c = cyc;
      set_line(which, 1'b0);
      repeat (c_N) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         set_line(which, d[k]);
         repeat (c_N) @(negedge clk);
      end
      set_line(which, p);
      repeat (c_N) @(negedge clk);
      set_line(which, s);
      repeat (c_N) @(negedge clk);
   endtask

   task automatic get_pulse(input bit which, input string name, output pulse_t p);
      bit ok;
      ok = 1'b0;
      p  = '{data: 4'h0, perr: 1'b0, ferr: 1'b0, cyc: 0};
      for (int i = 0; i < 200; i++) begin
         if ((which ? q1.size() : q0.size()) > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) p = which ? q1.pop_front() : q0.pop_front();
      check({name, " pulse seen"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic idle(input int n);
      rx0 = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   vec_t   vecs[18];
   pulse_t p;
   int     c;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rx0    = 1'b1;
      rx1    = 1'b1;

      for (int i = 0; i < 16; i++) begin
         vecs[i] = '{data: i[3:0], par_flip: 1'b0, stop: 1'b1,
                     exp_data: i[3:0], exp_perr: 1'b0, exp_ferr: 1'b0};
      end
      vecs[16] = '{data: 4'h7, par_flip: 1'b1, stop: 1'b1, exp_data: 4'h7, exp_perr: 1'b1, exp_ferr: 1'b0};
      vecs[17] = '{data: 4'h9, par_flip: 1'b1, stop: 1'b0, exp_data: 4'h9, exp_perr: 1'b1, exp_ferr: 1'b1};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset data_out", {28'd0, bus0.data_out}, 32'd0);
      check("reset flags", {27'd0, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.busy, 1'b0}, 32'd0);

      // Default frame 4'hA, with exact pulse timing (negedge after E28 sees cyc = c + 29)
      send_frame(0, 4'hA, 1'b0, 1'b1, c);
      get_pulse(0, "frame A", p);
      check("frame A word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'hA, 1'b0, 1'b0});
      check("frame A pulse cycle", p.cyc - c, 32'd29);
      idle(3);

      for (int i = 0; i < 18; i++) begin
         send_frame(0, vecs[i].data, (^vecs[i].data) ^ vecs[i].par_flip, vecs[i].stop, c);
         get_pulse(0, $sformatf("vec%0d", i), p);
         check($sformatf("vec%0d word/flags", i), {26'd0, p.data, p.perr, p.ferr},
               {26'd0, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
         idle(3);
      end

      // Odd parity receiver: data 3 needs parity bit 1
      send_frame(1, 4'h3, 1'b1, 1'b1, c);
      get_pulse(1, "odd good", p);
      check("odd good word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'h3, 1'b0, 1'b0});
      repeat (3) @(negedge clk);
      send_frame(1, 4'h3, 1'b0, 1'b1, c);
      get_pulse(1, "odd bad", p);
      check("odd bad word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'h3, 1'b1, 1'b0});
      repeat (3) @(negedge clk);

      // Back-to-back frames with no idle between stop and next start
      send_frame(0, 4'h5, 1'b0, 1'b1, c);
      send_frame(0, 4'hA, 1'b0, 1'b1, c);
      get_pulse(0, "b2b first", p);
      check("b2b first word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'h5, 1'b0, 1'b0});
      get_pulse(0, "b2b second", p);
      check("b2b second word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'hA, 1'b0, 1'b0});
      idle(3);

      // Break: stop low on 4'h5, line held low 40 more cycles
      send_frame(0, 4'h5, 1'b0, 1'b0, c);
      repeat (40) @(negedge clk);
      get_pulse(0, "break", p);
      check("break word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'h5, 1'b0, 1'b1});
      check("break busy held", {31'd0, bus0.busy}, 32'd1);
      check("break single frame", q0.size(), 32'd0);
      idle(5);
      check("break busy released", {31'd0, bus0.busy}, 32'd0);

      // One-cycle start glitch
      rx0 = 1'b0;
      @(negedge clk);
      rx0 = 1'b1;
      repeat (3) @(negedge clk);
      check("glitch busy in START", {31'd0, bus0.busy}, 32'd1);
      repeat (2) @(negedge clk);
      check("glitch busy dropped by E5", {31'd0, bus0.busy}, 32'd0);
      repeat (40) @(negedge clk);
      check("glitch no pulse", q0.size(), 32'd0);
      check("glitch outputs held", {26'd0, bus0.data_out, bus0.parity_err, bus0.frame_err},
            {26'd0, 4'h5, 1'b0, 1'b1});

      // Reset during data bit 2 of 4'hC, then a clean 4'hC
      rx0 = 1'b0;
      repeat (c_N) @(negedge clk);
      rx0 = 1'b0;
      repeat (c_N) @(negedge clk);
      rx0 = 1'b0;
      repeat (c_N) @(negedge clk);
      rx0 = 1'b1;
      repeat (2) @(negedge clk);
      check("mid-frame busy", {31'd0, bus0.busy}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async reset data_out", {28'd0, bus0.data_out}, 32'd0);
      check("async reset flags", {28'd0, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.busy}, 32'd0);
      rx0 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(0, 4'hC, 1'b0, 1'b1, c);
      get_pulse(0, "after reset", p);
      check("after reset word/flags", {26'd0, p.data, p.perr, p.ferr}, {26'd0, 4'hC, 1'b0, 1'b0});
      idle(5);

      check("total pulses even", n_pulse0, 32'd23);
      check("total pulses odd", n_pulse1, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
